// File: rtl/bus_sync_launch.sv
// rtl/bus_sync_launch.sv - source-side launcher holding a word stable under a level bus_enable
// Optional BUS_SYNC_ACK_EN: closed-loop four-phase ack handshake instead of timed hold/gap.
module bus_sync_launch #(
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 8,
  parameter int NUM_STAGES  = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
`ifdef BUS_SYNC_ACK_EN
  input  logic                 ack_async,
`endif
  output logic                 busy,
  output logic                 xfer_done
);

  typedef enum logic [1:0] {IDLE, ASSERT, RELEASE} state_t;

  state_t               state, state_nxt;
  logic [BUS_WIDTH-1:0] bus_nxt;
  logic                 en_nxt;
  logic                 done_nxt;
  logic                 accept;
  logic                 assert_exit;
  logic                 release_exit;

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  assign accept   = in_valid & in_ready;

`ifdef BUS_SYNC_ACK_EN
  logic [NUM_STAGES-1:0] ack_sync;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[NUM_STAGES-2:0], ack_async};
    end
  end

  assign assert_exit  = ack_sync[NUM_STAGES-1];
  assign release_exit = ~ack_sync[NUM_STAGES-1];
`else
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Counter holds remaining cycles minus one, so a zero count means "last cycle of this phase".
  always_comb begin
    cnt_nxt = cnt;
    case (state)
      IDLE:    if (accept) cnt_nxt = HOLD_LOAD;
      ASSERT:  cnt_nxt = (cnt == '0) ? GAP_LOAD : cnt - 1'b1;
      RELEASE: if (cnt != '0) cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign assert_exit  = (cnt == '0);
  assign release_exit = (cnt == '0);
`endif

  always_comb begin
    state_nxt = state;
    bus_nxt   = unsync_bus;
    en_nxt    = bus_enable;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ASSERT;
          bus_nxt   = in_data;
          en_nxt    = 1'b1;
        end
      end
      ASSERT: begin
        if (assert_exit) begin
          state_nxt = RELEASE;
          en_nxt    = 1'b0;
        end
      end
      RELEASE: begin
        if (release_exit) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        en_nxt    = 1'b0;
      end
    endcase
  end

  // Data and enable share one edge so the destination never sees enable ahead of data.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
      xfer_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      unsync_bus <= bus_nxt;
      bus_enable <= en_nxt;
      xfer_done  <= done_nxt;
    end
  end

endmodule
